// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory port, byte-lane alignment, load extension, stall and exceptions.
// Optional LSU_TIMEOUT_EN: abandon a BUSY access after TIMEOUT_CYCLES cycles without ack and raise an access fault.
module mem_stage_lsu
`ifdef LSU_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        me_valid,
   input  logic        me_flush,
   input  logic        me_mem_read,
   input  logic        me_mem_write,
   input  logic [2:0]  me_funct3,
   input  logic [31:0] me_alu_o,
   input  logic [31:0] me_rs2_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] me_mem_data,
   output logic        lsu_stall,
   output logic        lsu_exc,
   output logic [3:0]  lsu_exc_cause,
   output logic [31:0] lsu_exc_addr
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FAULT} state_t;

   state_t      r_state, w_next;
   logic        r_req, r_we, r_load, r_flushed;
   logic [31:0] r_addr, r_wdata, r_eaddr, r_mem_data, r_exc_addr;
   logic [3:0]  r_be, r_cause;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;

   logic        w_accept, w_byte, w_half, w_word, w_misal, w_start, w_mis_fault;
   logic        w_timeout, w_kill;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_shift, w_ext;
   logic [7:0]  w_b;
   logic [15:0] w_h;

   assign w_accept    = (r_state == S_IDLE) & me_valid & ~me_flush & (me_mem_read | me_mem_write);
   assign w_byte      = (me_funct3[1:0] == 2'b00);
   assign w_half      = (me_funct3[1:0] == 2'b01);
   assign w_word      = ~w_byte & ~w_half;
   assign w_misal     = (w_half & me_alu_o[0]) | (w_word & (|me_alu_o[1:0]));
   assign w_start     = w_accept & ~w_misal;
   assign w_mis_fault = w_accept & w_misal;
   // a flush in the ack cycle itself also suppresses writeback
   assign w_kill      = r_flushed | me_flush;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = me_rs2_data;
      if (!me_mem_read) begin
         if (w_byte) begin
            w_be    = 4'b0001 << me_alu_o[1:0];
            w_wdata = {4{me_rs2_data[7:0]}};
         end else if (w_half) begin
            w_be    = 4'b0011 << {me_alu_o[1], 1'b0};
            w_wdata = {2{me_rs2_data[15:0]}};
         end
      end
   end

   assign w_shift = dmem_rdata >> {r_off, 3'b000};
   assign w_b     = w_shift[7:0];
   assign w_h     = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (r_f3)
         3'b000:  w_ext = {{24{w_b[7]}}, w_b};
         3'b001:  w_ext = {{16{w_h[15]}}, w_h};
         3'b100:  w_ext = {24'd0, w_b};
         3'b101:  w_ext = {16'd0, w_h};
         default: w_ext = dmem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [7:0] r_cnt;

   assign w_timeout = (r_state == S_BUSY) & ~dmem_ack & (r_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)                                 r_cnt <= 8'd0;
      else if (w_start)                        r_cnt <= 8'd0;
      else if ((r_state == S_BUSY) & ~dmem_ack) r_cnt <= r_cnt + 8'd1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start)          w_next = S_BUSY;
            else if (w_mis_fault) w_next = S_FAULT;
         end
         S_BUSY: begin
            if (dmem_ack)       w_next = w_kill ? S_IDLE : S_DONE;
            else if (w_timeout) w_next = S_FAULT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_load     <= 1'b0;
         r_flushed  <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_eaddr    <= 32'd0;
         r_mem_data <= 32'd0;
         r_exc_addr <= 32'd0;
         r_be       <= 4'd0;
         r_cause    <= 4'd0;
         r_f3       <= 3'd0;
         r_off      <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_req     <= 1'b1;
                  r_we      <= ~me_mem_read;
                  r_addr    <= {me_alu_o[31:2], 2'b00};
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_load    <= me_mem_read;
                  r_f3      <= me_funct3;
                  r_off     <= me_alu_o[1:0];
                  r_eaddr   <= me_alu_o;
                  r_flushed <= 1'b0;
               end else if (w_mis_fault) begin
                  r_cause    <= me_mem_read ? 4'd4 : 4'd6;
                  r_exc_addr <= me_alu_o;
               end
            end
            S_BUSY: begin
               if (me_flush) r_flushed <= 1'b1;
               if (dmem_ack) begin
                  r_req <= 1'b0;
                  r_we  <= 1'b0;
                  if (r_load & ~w_kill) r_mem_data <= w_ext;
               end else if (w_timeout) begin
                  r_req      <= 1'b0;
                  r_we       <= 1'b0;
                  r_cause    <= r_load ? 4'd5 : 4'd7;
                  r_exc_addr <= r_eaddr;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_req      = r_req;
   assign dmem_we       = r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign dmem_be       = r_be;
   assign me_mem_data   = r_mem_data;
   assign lsu_stall     = w_start | (r_state == S_BUSY);
   assign lsu_exc       = (r_state == S_FAULT);
   assign lsu_exc_cause = r_cause;
   assign lsu_exc_addr  = r_exc_addr;

endmodule
